// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo responder.
// UART_ECHO_NAK_EN selects NAK echo of framing errors.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SENDING
  } echo_state_t;

  localparam logic [7:0] NAK_BYTE = 8'h15;

endpackage

// File: rtl/echo_fifo.sv
// Synchronous byte FIFO with combinational head and exact occupancy.
// DEPTH must be a power of two, at least 2.
module echo_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       syncReset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 wdata,
  output logic [7:0]                 rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (syncReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(push) - LW'(pop);
    end
  end

endmodule

// File: rtl/uart_echo_responder.sv
// Echoes received UART bytes back out through a FIFO, counting errors/drops.
// UART_ECHO_NAK_EN: framing errors push NAK_BYTE instead of being discarded.
module uart_echo_responder
  import uart_echo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   syncReset,
  input  logic [7:0]             rxData,
  input  logic                   rxDone,
  input  logic                   rxErr,
  output logic [7:0]             txData,
  output logic                   txValid,
  input  logic                   txBusy,
  input  logic                   txDone,
  output logic [$clog2(DEPTH):0] fifoLevel,
  output logic                   overflow,
  output logic [CNT_W-1:0]       errCount,
  output logic [CNT_W-1:0]       dropCount
);

  echo_state_t state;

  logic       push_req;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [7:0] wdata;
  logic [7:0] head;

`ifdef UART_ECHO_NAK_EN
  assign push_req = rxDone;
  assign wdata    = rxErr ? NAK_BYTE : rxData;
`else
  assign push_req = rxDone && !rxErr;
  assign wdata    = rxData;
`endif

  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign pop  = (state == LOAD) && txBusy;
  assign push = push_req && (!full || pop);

  echo_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .syncReset(syncReset),
    .push     (push),
    .pop      (pop),
    .wdata    (wdata),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .level    (fifoLevel)
  );

  always_ff @(posedge clk) begin
    if (syncReset) begin
      state   <= IDLE;
      txValid <= 1'b0;
      txData  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty && !txBusy) begin
            state   <= LOAD;
            txValid <= 1'b1;
            txData  <= head;
          end
        end
        LOAD: begin
          if (txBusy) begin
            state   <= SENDING;
            txValid <= 1'b0;
          end
        end
        SENDING: begin
          if (txDone) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          txValid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (syncReset) begin
      overflow  <= 1'b0;
      errCount  <= '0;
      dropCount <= '0;
    end else begin
      overflow <= push_req && !push;
      if (push_req && !push && (dropCount != '1)) begin
        dropCount <= dropCount + CNT_W'(1);
      end
      if (rxDone && rxErr && (errCount != '1)) begin
        errCount <= errCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder: directed stimulus, queued
// expectations, and a monitor checking each byte presented on txValid.
module tb_uart_echo_responder;

  logic       clk = 1'b0;
  logic       syncReset = 1'b0;
  logic [7:0] rxData = '0;
  logic       rxDone = 1'b0;
  logic       rxErr = 1'b0;
  logic [7:0] txData;
  logic       txValid;
  logic       txBusy = 1'b0;
  logic       txDone = 1'b0;
  logic [3:0] fifoLevel;
  logic       overflow;
  logic [7:0] errCount;
  logic [7:0] dropCount;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  bit seen = 1'b0;

  uart_echo_responder #(
    .DEPTH(8),
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .syncReset(syncReset),
    .rxData   (rxData),
    .rxDone   (rxDone),
    .rxErr    (rxErr),
    .txData   (txData),
    .txValid  (txValid),
    .txBusy   (txBusy),
    .txDone   (txDone),
    .fifoLevel(fifoLevel),
    .overflow (overflow),
    .errCount (errCount),
    .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit err,
                           input bit expect_echo, input logic [7:0] echo);
    if (expect_echo) exp_q.push_back(echo);
    rxData = d;
    rxErr  = err;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    rxErr  = 1'b0;
  endtask

  // Plays the transmitter for one byte: accept, stay busy, then signal done.
  task automatic run_tx();
    int n = 0;
    while (!txValid && n < 50) begin
      tick();
      n++;
    end
    check("tx_wait", 32'(txValid), 32'd1);
    txBusy = 1'b1;
    tick();
    check("tx_accept", 32'(txValid), 32'd0);
    tick();
    txDone = 1'b1;
    txBusy = 1'b0;
    tick();
    txDone = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!txValid) begin
      seen = 1'b0;
    end else if (!seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx: got %0h expected none", txData);
      end else begin
        check("echo_byte", 32'(txData), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset
    syncReset = 1'b1;
    tick();
    tick();
    syncReset = 1'b0;
    check("rst_txValid", 32'(txValid), 32'd0);
    check("rst_txData", 32'(txData), 32'd0);
    check("rst_level", 32'(fifoLevel), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_errCount", 32'(errCount), 32'd0);
    check("rst_dropCount", 32'(dropCount), 32'd0);

    // Single byte latency and handshake
    send_byte(8'hA5, 1'b0, 1'b1, 8'hA5);
    check("single_lat1", 32'(txValid), 32'd0);
    check("single_level1", 32'(fifoLevel), 32'd1);
    tick();
    check("single_lat2", 32'(txValid), 32'd1);
    check("single_data", 32'(txData), 32'hA5);
    txBusy = 1'b1;
    tick();
    check("single_pop_valid", 32'(txValid), 32'd0);
    check("single_pop_level", 32'(fifoLevel), 32'd0);
    tick();
    txDone = 1'b1;
    txBusy = 1'b0;
    tick();
    txDone = 1'b0;
    tick();
    check("single_idle", 32'(txValid), 32'd0);

    // Overflow: 9 bytes into 8 entries while tx stays busy
    txBusy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i), 1'b0, 1'b1, 8'(i));
      check("ovf_no_pulse", 32'(overflow), 32'd0);
    end
    send_byte(8'h08, 1'b0, 1'b0, 8'h00);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_drop", 32'(dropCount), 32'd1);
    tick();
    check("ovf_pulse_end", 32'(overflow), 32'd0);
    check("ovf_level", 32'(fifoLevel), 32'd8);
    check("ovf_held", 32'(txValid), 32'd0);
    txBusy = 1'b0;
    for (int i = 0; i < 8; i++) run_tx();
    check("ovf_drained", 32'(fifoLevel), 32'd0);

    // Full FIFO with push coinciding with the pop edge
    txBusy = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b1, 8'h10 + 8'(i));
    check("full_level", 32'(fifoLevel), 32'd8);
    txBusy = 1'b0;
    tick();
    check("full_load", 32'(txValid), 32'd1);
    exp_q.push_back(8'h18);
    txBusy = 1'b1;
    rxData = 8'h18;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    check("full_pp_level", 32'(fifoLevel), 32'd8);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("full_pp_drop", 32'(dropCount), 32'd1);
    tick();
    txDone = 1'b1;
    txBusy = 1'b0;
    tick();
    txDone = 1'b0;
    for (int i = 0; i < 8; i++) run_tx();
    check("full_drained", 32'(fifoLevel), 32'd0);

    // Framing error
`ifdef UART_ECHO_NAK_EN
    send_byte(8'h3C, 1'b1, 1'b1, 8'h15);
    check("ferr_count", 32'(errCount), 32'd1);
    run_tx();
`else
    send_byte(8'h3C, 1'b1, 1'b0, 8'h00);
    check("ferr_count", 32'(errCount), 32'd1);
    check("ferr_level", 32'(fifoLevel), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ferr_no_tx", 32'(txValid), 32'd0);
    end
`endif
    check("ferr_drop", 32'(dropCount), 32'd1);

    // Reset while SENDING with 3 bytes still queued
    txBusy = 1'b1;
    send_byte(8'h21, 1'b0, 1'b1, 8'h21);
    send_byte(8'h22, 1'b0, 1'b0, 8'h00);
    send_byte(8'h23, 1'b0, 1'b0, 8'h00);
    send_byte(8'h24, 1'b0, 1'b0, 8'h00);
    txBusy = 1'b0;
    tick();
    check("mid_load", 32'(txValid), 32'd1);
    txBusy = 1'b1;
    tick();
    check("mid_level", 32'(fifoLevel), 32'd3);
    syncReset = 1'b1;
    tick();
    syncReset = 1'b0;
    txBusy = 1'b0;
    check("mid_rst_valid", 32'(txValid), 32'd0);
    check("mid_rst_level", 32'(fifoLevel), 32'd0);
    check("mid_rst_err", 32'(errCount), 32'd0);
    check("mid_rst_drop", 32'(dropCount), 32'd0);
    txDone = 1'b1;
    tick();
    txDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_stray_done", 32'(txValid), 32'd0);
    end
    send_byte(8'h5A, 1'b0, 1'b1, 8'h5A);
    run_tx();
    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_echo_responder.md
Name: uart_echo_responder

Overview:
- Far-end responder for the UART link. Consumes bytes from a UartRxEn instance and echoes them back through a UartTxEn instance.
- Decouples the rx and tx rates with an internal FIFO.
- Counts framing errors and dropped bytes.
- Controller only: sits between the rx outputs and the tx inputs and does not instantiate either.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- CNT_W, 8, width of the saturating error and drop counters.

Ports:
- clk  input  1  system clock
- syncReset  input  1  synchronous, active-high reset
- rxData  input  8  byte from UartRxEn data
- rxDone  input  1  one-cycle pulse from UartRxEn done; rxData valid this cycle
- rxErr  input  1  UartRxEn err; qualified by rxDone
- txData  output  8  byte to UartTxEn data
- txValid  output  1  to UartTxEn valid
- txBusy  input  1  from UartTxEn busy
- txDone  input  1  one-cycle pulse from UartTxEn done
- fifoLevel  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  one-cycle pulse when a byte is dropped because the FIFO is full
- errCount  output  CNT_W  saturating count of rxDone&&rxErr events
- dropCount  output  CNT_W  saturating count of overflow drops

Behaviour:
- Reset (syncReset=1 at a clk edge):
  - txValid=0, txData=0, fifoLevel=0, overflow=0, errCount=0, dropCount=0.
  - FSM goes to IDLE and FIFO pointers clear.
  - Takes effect at that edge, including mid-transmit. A stray txDone or txBusy afterwards is ignored except as described below.
- Push: rxDone && !rxErr.
  - If not full, or a pop occurs the same cycle, rxData is written at tail and the level updates at that edge.
  - Otherwise the byte is dropped, overflow pulses for one cycle and dropCount increments (saturating at all-ones).
- rxDone && rxErr: byte discarded and errCount increments (saturating). Never pushed unless UART_ECHO_NAK_EN is defined.
- FSM states: IDLE, LOAD, SENDING.
  - IDLE: if FIFO not empty && !txBusy, go to LOAD and register txValid=1, txData=head.
  - LOAD: hold txValid and txData stable until txBusy is sampled 1. At that edge: pop head, txValid=0, go to SENDING.
  - SENDING: wait for txDone==1, then go to IDLE. txBusy is not used as the completion condition.
- Latency: an rxDone into an empty FIFO with tx idle gives txValid=1 at the second clk edge after the rxDone edge.
- Ordering: bytes leave strictly in arrival order; no reordering or duplication.
- Simultaneous push and pop: allowed in every state. Level is unchanged, and a push into a full FIFO on a pop cycle is accepted.
- Pop never occurs while empty, because LOAD is entered only when non-empty.
- Pointers wrap modulo DEPTH. fifoLevel is the exact count 0..DEPTH.

Optional Feature:
- Macro UART_ECHO_NAK_EN.
- Defined: rxDone && rxErr pushes constant NAK byte 8'h15 through the same push path (full-FIFO drop rules apply), and errCount still increments.
- Undefined: erroneous bytes are silently discarded (counted only). No NAK logic is synthesised.

Decomposition:
- Package uart_echo_pkg holds:
  - typedef enum logic [1:0] echo_state_t {IDLE, LOAD, SENDING}
  - localparam logic [7:0] NAK_BYTE = 8'h15
- One sub-module, echo_fifo:
  - synchronous FIFO parameterised by DEPTH, 8-bit data.
  - ports push, pop, wdata, rdata (head, combinational), full, empty, level.
  - same clk/syncReset convention.
- FSM, counters and overflow logic live in uart_echo_responder.

Test Plan:
- Reset: assert syncReset for 2 cycles → all outputs 0, fifoLevel=0.
- Single byte: rxData=8'hA5 with rxDone pulse, txBusy=0 → txValid=1, txData=8'hA5 two edges later. Drive txBusy=1 → next edge txValid=0, fifoLevel=0. Then txDone pulse → IDLE.
- Overflow: hold txBusy=1 and push 9 bytes 8'h00..8'h08 → fifoLevel=8, overflow pulses once on the 9th, dropCount=1. Release txBusy → echo sequence is 8'h00..8'h07.
- Full push+pop: fill to 8, then rxDone coincident with the LOAD→SENDING pop edge → byte accepted, fifoLevel stays 8, dropCount unchanged.
- Framing error: rxDone with rxErr=1, rxData=8'h3C → errCount=1.
  - Without macro: no txValid.
  - With UART_ECHO_NAK_EN: txData=8'h15 echoed.
- Reset mid-transmit: syncReset in SENDING with 3 bytes queued → txValid=0, fifoLevel=0 next edge. Subsequent stray txDone does not transmit; a new byte echoes normally.
